// File: rtl/alarm_match_ctrl_if.sv
// Purpose : bundles the live-time, alarm-control and status signals of alarm_match_ctrl.
// Ports   : master drives time/tick/control inputs and observes status; slave is the controller.
// Notes   : clock and clearN are kept as plain ports on the controller, not in this bundle.
`timescale 1ns/1ps
interface alarm_match_ctrl_if #(
    parameter int HOUR_W = 5,
    parameter int MIN_W  = 6
);
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [MIN_W-1:0]  seconds;
    logic              secTick;
    logic              alarmEnable;
    logic              loadAlarm;
    logic [HOUR_W-1:0] alarmHoursIn;
    logic [MIN_W-1:0]  alarmMinutesIn;
    logic              snooze;
    logic              stop;
    logic [HOUR_W-1:0] alarmHours;
    logic [MIN_W-1:0]  alarmMinutes;
    logic              ringing;
    logic              snoozing;
    logic              buzzer;
    logic [1:0]        snoozeCount;
    logic              loadError;

    modport master (
        output hours, minutes, seconds, secTick, alarmEnable, loadAlarm,
               alarmHoursIn, alarmMinutesIn, snooze, stop,
        input  alarmHours, alarmMinutes, ringing, snoozing, buzzer, snoozeCount, loadError
    );

    modport slave (
        input  hours, minutes, seconds, secTick, alarmEnable, loadAlarm,
               alarmHoursIn, alarmMinutesIn, snooze, stop,
        output alarmHours, alarmMinutes, ringing, snoozing, buzzer, snoozeCount, loadError
    );
endinterface

// File: rtl/alarm_match_ctrl.sv
// Purpose : stores the alarm time, edge-detects a match with the live time, runs ring/snooze/stop FSM.
// Latency : all outputs registered; ringing rises the cycle after the hh:mm:00 match is sampled.
// Ports   : clock, clearN (async active-low) plus the alarm_match_ctrl_if slave bundle; no backpressure.
`timescale 1ns/1ps
module alarm_match_ctrl #(
    parameter int HOUR_W      = 5,
    parameter int MIN_W       = 6,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int CNT_W       = 9,
    parameter int RST_HOURS   = 6,
    parameter int RST_MINUTES = 0
) (
    input  logic            clock,
    input  logic            clearN,
    alarm_match_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    localparam logic [HOUR_W-1:0] HOUR_MAX   = HOUR_W'(23);
    localparam logic [MIN_W-1:0]  MIN_MAX    = MIN_W'(59);
    localparam logic [CNT_W-1:0]  RING_LAST  = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0]  SNOOZE_LEN = CNT_W'(SNOOZE_SECS);
    localparam logic [1:0]        SNOOZE_LIM = 2'(MAX_SNOOZE);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic              beat_q, beat_d;
    logic [1:0]        snooze_cnt_q, snooze_cnt_d;
    logic              match_prev_q, match_prev_d;
    logic [HOUR_W-1:0] alarm_hours_q, alarm_hours_d;
    logic [MIN_W-1:0]  alarm_minutes_q, alarm_minutes_d;
    logic              ringing_q, ringing_d;
    logic              snoozing_q, snoozing_d;
    logic              buzzer_q, buzzer_d;
    logic              load_error_q, load_error_d;

    logic match_now, trigger, load_ok, go_idle, enter_ring;

    always_comb begin
        state_d         = state_q;
        sec_cnt_d       = sec_cnt_q;
        beat_d          = beat_q;
        snooze_cnt_d    = snooze_cnt_q;
        alarm_hours_d   = alarm_hours_q;
        alarm_minutes_d = alarm_minutes_q;
        load_error_d    = 1'b0;
        go_idle         = 1'b0;
        enter_ring      = 1'b0;

        // Compare against the stored alarm (not the one being loaded this cycle).
        match_now    = bus.alarmEnable && (bus.hours == alarm_hours_q) &&
                       (bus.minutes == alarm_minutes_q) && (bus.seconds == '0);
        trigger      = match_now && !match_prev_q;
        match_prev_d = match_now;

        load_ok = (bus.alarmHoursIn <= HOUR_MAX) && (bus.alarmMinutesIn <= MIN_MAX);
        if (bus.loadAlarm) begin
            if (load_ok) begin
                alarm_hours_d   = bus.alarmHoursIn;
                alarm_minutes_d = bus.alarmMinutesIn;
            end else begin
                load_error_d = 1'b1;
            end
        end

        // Event priority: disable/load, stop, snooze, tick expiry, trigger.
        // A tick that coincides with a transition is swallowed by it.
        if (!bus.alarmEnable || bus.loadAlarm) begin
            go_idle = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trigger) enter_ring = 1'b1;
                end
                RINGING: begin
                    if (bus.stop) begin
                        go_idle = 1'b1;
                    end else if (bus.snooze && (snooze_cnt_q < SNOOZE_LIM)) begin
                        state_d      = SNOOZE;
                        sec_cnt_d    = SNOOZE_LEN;
                        snooze_cnt_d = snooze_cnt_q + 2'd1;
                    end else if (bus.secTick) begin
                        if (sec_cnt_q == RING_LAST) begin
                            go_idle = 1'b1;
                        end else begin
                            sec_cnt_d = sec_cnt_q + CNT_W'(1);
                            beat_d    = !beat_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.stop) begin
                        go_idle = 1'b1;
                    end else if (bus.secTick) begin
                        if (sec_cnt_q == CNT_W'(1)) enter_ring = 1'b1;
                        else                        sec_cnt_d = sec_cnt_q - CNT_W'(1);
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end

        if (enter_ring) begin
            state_d   = RINGING;
            sec_cnt_d = '0;
            beat_d    = 1'b1;
        end
        if (go_idle) begin
            state_d      = IDLE;
            sec_cnt_d    = '0;
            snooze_cnt_d = '0;
            beat_d       = 1'b0;
        end

        // Outputs are registered copies of the next state so they align with it.
        ringing_d  = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
        buzzer_d   = ringing_d && beat_d;
    end

    always_ff @(posedge clock or negedge clearN) begin
        if (!clearN) begin
            state_q         <= IDLE;
            sec_cnt_q       <= '0;
            beat_q          <= 1'b0;
            snooze_cnt_q    <= '0;
            match_prev_q    <= 1'b0;
            alarm_hours_q   <= HOUR_W'(RST_HOURS);
            alarm_minutes_q <= MIN_W'(RST_MINUTES);
            ringing_q       <= 1'b0;
            snoozing_q      <= 1'b0;
            buzzer_q        <= 1'b0;
            load_error_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            sec_cnt_q       <= sec_cnt_d;
            beat_q          <= beat_d;
            snooze_cnt_q    <= snooze_cnt_d;
            match_prev_q    <= match_prev_d;
            alarm_hours_q   <= alarm_hours_d;
            alarm_minutes_q <= alarm_minutes_d;
            ringing_q       <= ringing_d;
            snoozing_q      <= snoozing_d;
            buzzer_q        <= buzzer_d;
            load_error_q    <= load_error_d;
        end
    end

    assign bus.alarmHours   = alarm_hours_q;
    assign bus.alarmMinutes = alarm_minutes_q;
    assign bus.ringing      = ringing_q;
    assign bus.snoozing     = snoozing_q;
    assign bus.buzzer       = buzzer_q;
    assign bus.snoozeCount  = snooze_cnt_q;
    assign bus.loadError    = load_error_q;
endmodule
